// File: rtl/gf128_pkg.sv
// gf128_pkg: shared constants and types for the GF(2^128) GHASH datapath.
//
// Contents:
//   GF128_W        operand width (128)
//   GF128_PW       unreduced product width (256)
//   GF128_CLMUL_D  digit width of the serial carry-less multiplier
//   GF128_CLMUL_N  iterations per multiply (GF128_W / GF128_CLMUL_D)
//   GF128_CNT_W    width of the iteration counter
//   gf128_state_e  multiplier FSM states (idle / run / done)
//
// Configuration macro:
//   GF128_CLMUL_DIGIT4_EN  defined   -> D = 4, N = 32
//                          undefined -> D = 1, N = 128
package gf128_pkg;

   localparam int unsigned GF128_W  = 128;
   localparam int unsigned GF128_PW = 256;

`ifdef GF128_CLMUL_DIGIT4_EN
   localparam int unsigned GF128_CLMUL_D = 4;
`else
   localparam int unsigned GF128_CLMUL_D = 1;
`endif

   localparam int unsigned GF128_CLMUL_N = GF128_W / GF128_CLMUL_D;

   // N is a power of two, so the counter wraps to zero right after the last iteration.
   localparam int unsigned GF128_CNT_W = $clog2(GF128_CLMUL_N);

   localparam logic [GF128_CNT_W-1:0] GF128_CNT_LAST = GF128_CNT_W'(GF128_CLMUL_N - 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } gf128_state_e;

endpackage

// File: rtl/gf128_clmul_digit.sv
// gf128_clmul_digit: combinational D-bit x 128-bit carry-less partial product.
//
// Ports:
//   a      in  128      multiplicand, bit i = coefficient of x^i
//   digit  in  D        multiplier digit, digit[k] weights a by x^k
//   pp     out 256      XOR of (a << k) over all set digit bits
//
// D comes from gf128_pkg (1, or 4 when GF128_CLMUL_DIGIT4_EN is defined).
module gf128_clmul_digit
   import gf128_pkg::*;
(
   input  logic [GF128_W-1:0]       a,
   input  logic [GF128_CLMUL_D-1:0] digit,
   output logic [GF128_PW-1:0]      pp
);

   logic [GF128_PW-1:0] a_ext;

   assign a_ext = {{(GF128_PW - GF128_W){1'b0}}, a};

   always_comb begin
      pp = '0;
      for (int k = 0; k < int'(GF128_CLMUL_D); k++) begin
         if (digit[k]) begin
            pp = pp ^ (a_ext << k);
         end
      end
   end

endmodule

// File: rtl/gf128_clmul_serial.sv
// gf128_clmul_serial: digit-serial 128x128 carry-less multiplier, 255-bit unreduced product.
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    operand pair valid
//   in_ready   out  1    high only while idle
//   a          in   128  multiplicand, bit i = coefficient of x^i
//   b          in   128  multiplier, same ordering
//   out_valid  out  1    p holds a completed product
//   out_ready  in   1    consumer accepts p
//   p          out  256  product, bit 255 always 0
//   busy       out  1    high while running or holding a result
//
// Configuration macro: GF128_CLMUL_DIGIT4_EN selects 4 multiplier bits per cycle (32 cycles)
// instead of 1 bit per cycle (128 cycles). Results are identical in both builds.
//
// The multiplier is consumed MSB-first (Horner): every cycle the accumulator is shifted up by
// D and the partial product of the next D multiplier bits is XORed in.
module gf128_clmul_serial
   import gf128_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [GF128_W-1:0]  a,
   input  logic [GF128_W-1:0]  b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [GF128_PW-1:0] p,
   output logic                busy
);

   gf128_state_e state_q, state_d;

   logic [GF128_CNT_W-1:0] cnt_q, cnt_d;
   logic [GF128_W-1:0]     a_q, a_d;
   logic [GF128_W-1:0]     b_q, b_d;
   logic [GF128_PW-1:0]    acc_q, acc_d;
   logic [GF128_PW-1:0]    pp;
   logic                   accept;
   logic                   last_iter;

   // Acceptance depends on state, not on in_ready, so in_ready stays a pure state decode.
   assign accept    = in_valid && (state_q == StIdle);
   assign last_iter = (cnt_q == GF128_CNT_LAST);

   // b_q shifts up by D each iteration, so its top D bits are always the current digit
   // (equivalent to indexing b at 127 - cnt*D without a variable-position mux).
   gf128_clmul_digit u_digit (
      .a     (a_q),
      .digit (b_q[GF128_W-1 -: GF128_CLMUL_D]),
      .pp    (pp)
   );

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (last_iter) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: output decode
   // ------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
         end
         StRun: begin
            busy = 1'b1;
         end
         StDone: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            busy      = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath next-state
   // ------------------------------------------------------------------
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               a_d   = a;
               b_d   = b;
               acc_d = '0;
               cnt_d = '0;
            end
         end
         StRun: begin
            // Max degree 254 after the last step, so the 256-bit shift never drops a bit.
            acc_d = (acc_q << GF128_CLMUL_D) ^ pp;
            b_d   = b_q << GF128_CLMUL_D;
            cnt_d = cnt_q + GF128_CNT_W'(1);
         end
         StDone: begin
            acc_d = acc_q;
         end
         default: begin
            acc_d = acc_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   assign p = acc_q;

endmodule
